fetch_buffer: RTL

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/uarch_pkg.sv | 17 +
 rtl/fetch_buffer_if.sv | 60 ++++++
 rtl/fetch_buffer.sv | 89 ++++++++
 3 files changed

// File: rtl/uarch_pkg.sv
// Shared micro-architecture types and constants for the front end.
// Holds the fetch-pair payload and the default fetch buffer depth.
package uarch_pkg;

    localparam int unsigned CPU_ADDR_BITS   = 32;
    localparam int unsigned CPU_INST_BITS   = 32;
    localparam int unsigned FETCH_BUF_DEPTH = 4;

    // One fetch group: two consecutive slots that always travel together
    typedef struct packed {
        logic [CPU_ADDR_BITS-1:0] pc0;
        logic [CPU_ADDR_BITS-1:0] pc1;
        logic [CPU_INST_BITS-1:0] inst0;
        logic [CPU_INST_BITS-1:0] inst1;
    } fetch_pair_t;

endpackage

// File: rtl/fetch_buffer_if.sv
// Fetch-to-decode handshake bundle for the fetch buffer.
// The master side is fetch/decode control; the slave side is the buffer.
interface fetch_buffer_if
    import uarch_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_BUF_DEPTH
);

    localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

    logic                     flush;
    logic                     buf_rdy;
    logic                     fetch_val;
    logic [CPU_ADDR_BITS-1:0] fetch_pc0;
    logic [CPU_ADDR_BITS-1:0] fetch_pc1;
    logic [CPU_INST_BITS-1:0] fetch_inst0;
    logic [CPU_INST_BITS-1:0] fetch_inst1;
    logic                     decode_rdy;
    logic [CPU_ADDR_BITS-1:0] inst0_pc;
    logic [CPU_ADDR_BITS-1:0] inst1_pc;
    logic [CPU_INST_BITS-1:0] inst0;
    logic [CPU_INST_BITS-1:0] inst1;
    logic                     inst_val;
    logic [OCC_W-1:0]         occupancy;

    modport master (
        output flush,
        output fetch_val,
        output fetch_pc0,
        output fetch_pc1,
        output fetch_inst0,
        output fetch_inst1,
        output decode_rdy,
        input  buf_rdy,
        input  inst0_pc,
        input  inst1_pc,
        input  inst0,
        input  inst1,
        input  inst_val,
        input  occupancy
    );

    modport slave (
        input  flush,
        input  fetch_val,
        input  fetch_pc0,
        input  fetch_pc1,
        input  fetch_inst0,
        input  fetch_inst1,
        input  decode_rdy,
        output buf_rdy,
        output inst0_pc,
        output inst1_pc,
        output inst0,
        output inst1,
        output inst_val,
        output occupancy
    );

endinterface

// File: rtl/fetch_buffer.sv
// Circular FIFO of instruction pairs between fetch and decode, zero-latency head read.
// Optional same-cycle empty-buffer bypass is enabled by defining FETCH_BUF_BYPASS_EN.
module fetch_buffer
    import uarch_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_BUF_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    fetch_buffer_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    fetch_pair_t      r_mem [DEPTH];

    logic        w_empty;
    logic        w_full;
    logic        w_push;
    logic        w_pop;
    logic        w_inst_val;
    logic        w_byp_take;
    fetch_pair_t w_fetch_pair;
    fetch_pair_t w_head_mem;
    fetch_pair_t w_head;

    // Pointer MSB is the wrap bit distinguishing full from empty
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[IDX_W-1:0] == r_rptr[IDX_W-1:0]) &&
                     (r_wptr[IDX_W] != r_rptr[IDX_W]);

    assign w_fetch_pair.pc0   = bus.fetch_pc0;
    assign w_fetch_pair.pc1   = bus.fetch_pc1;
    assign w_fetch_pair.inst0 = bus.fetch_inst0;
    assign w_fetch_pair.inst1 = bus.fetch_inst1;

    assign w_head_mem = w_empty ? fetch_pair_t'('0) : r_mem[r_rptr[IDX_W-1:0]];

`ifdef FETCH_BUF_BYPASS_EN
    logic w_bypass;

    // An empty buffer forwards the incoming pair; if decode takes it, it is never stored
    assign w_bypass   = w_empty && bus.fetch_val && !bus.flush;
    assign w_byp_take = w_bypass && bus.decode_rdy;
    assign w_inst_val = !w_empty || w_bypass;
    assign w_head     = w_bypass ? w_fetch_pair : w_head_mem;
`else
    assign w_byp_take = 1'b0;
    assign w_inst_val = !w_empty;
    assign w_head     = w_head_mem;
`endif

    // Push is gated only by full, so a same-cycle pop never frees a slot early
    assign w_push = bus.fetch_val && !w_full && !bus.flush && !w_byp_take;
    assign w_pop  = !w_empty && bus.decode_rdy && !bus.flush;

    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
        end
    end

    // Storage is intentionally not reset; pointers alone define validity
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_mem[r_wptr[IDX_W-1:0]] <= w_fetch_pair;
        end
    end

    assign bus.buf_rdy   = !w_full;
    assign bus.inst_val  = w_inst_val;
    assign bus.inst0_pc  = w_head.pc0;
    assign bus.inst1_pc  = w_head.pc1;
    assign bus.inst0     = w_head.inst0;
    assign bus.inst1     = w_head.inst1;
    assign bus.occupancy = r_wptr - r_rptr;

endmodule
